// File: rtl/bagaj_hakem_pkg.sv
// bagaj_pkg: shared types and default constants for the baggage-fee
// arbiter (bagaj_hakem) and its interface.
//   durum_e        : controller state encoding (BOS, HESAP, BEKLE, KAPALI)
//   MAX_YOLCU_DEF  : default number of bags per flight
//   AGIRLIK_W_DEF  : default weight width per desk
//   UCRET_W        : fee width
//   SAYAC_W        : passenger counter width
//   GELIR_W        : revenue accumulator width (BAGAJ_ISTATISTIK_EN builds)
package bagaj_pkg;

  typedef enum logic [1:0] {
    BOS    = 2'd0,
    HESAP  = 2'd1,
    BEKLE  = 2'd2,
    KAPALI = 2'd3
  } durum_e;

  localparam int MAX_YOLCU_DEF = 50;
  localparam int AGIRLIK_W_DEF = 6;
  localparam int UCRET_W       = 8;
  localparam int SAYAC_W       = 6;
  localparam int GELIR_W       = 16;

endpackage

// File: rtl/bagaj_hakem_if.sv
// bagaj_hakem_if: groups the desk-side and fee-unit-side signals of the
// baggage-fee arbiter.
//   Desk side : istek, agirlik_in, yeni_ucus (to arbiter);
//               kabul, sonuc_gecerli, ucret_out, yolcu_sayisi, ucus_kapali
//               (from arbiter)
//   Fee unit  : bavul_basla, bavul_agirlik, bavul_sifirla (from arbiter);
//               bavul_ucret, bavul_bitti (to arbiter)
// Optional macro BAGAJ_ISTATISTIK_EN adds toplam_gelir (flight revenue).
// Modports: master = arbiter, slave = desks + fee unit.
interface bagaj_hakem_if
  import bagaj_pkg::*;
#(
  parameter int N_KONTUAR = 4,
  parameter int AGIRLIK_W = AGIRLIK_W_DEF
);

  logic [N_KONTUAR-1:0]           istek;
  logic [N_KONTUAR*AGIRLIK_W-1:0] agirlik_in;
  logic                           yeni_ucus;
  logic [N_KONTUAR-1:0]           kabul;
  logic [N_KONTUAR-1:0]           sonuc_gecerli;
  logic [UCRET_W-1:0]             ucret_out;
  logic [SAYAC_W-1:0]             yolcu_sayisi;
  logic                           ucus_kapali;
  logic                           bavul_basla;
  logic [AGIRLIK_W-1:0]           bavul_agirlik;
  logic                           bavul_sifirla;
  logic [UCRET_W-1:0]             bavul_ucret;
  logic                           bavul_bitti;
`ifdef BAGAJ_ISTATISTIK_EN
  logic [GELIR_W-1:0]             toplam_gelir;
`endif

  modport master (
    input  istek, agirlik_in, yeni_ucus, bavul_ucret, bavul_bitti,
    output kabul, sonuc_gecerli, ucret_out, yolcu_sayisi, ucus_kapali,
           bavul_basla, bavul_agirlik, bavul_sifirla
`ifdef BAGAJ_ISTATISTIK_EN
    , output toplam_gelir
`endif
  );

  modport slave (
    output istek, agirlik_in, yeni_ucus, bavul_ucret, bavul_bitti,
    input  kabul, sonuc_gecerli, ucret_out, yolcu_sayisi, ucus_kapali,
           bavul_basla, bavul_agirlik, bavul_sifirla
`ifdef BAGAJ_ISTATISTIK_EN
    , input toplam_gelir
`endif
  );

endinterface

// File: rtl/bagaj_hakem_rr_hakem.sv
// rr_hakem: purely combinational round-robin picker.
//   req  : request vector, one bit per desk
//   ptr  : index where the search starts (owned by the caller)
//   gnt  : one-hot grant (all zero when no request)
//   idx  : binary index of the granted desk
//   any  : at least one request present
module rr_hakem #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Walk the desks starting at ptr and wrapping; first hit wins.
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bagaj_hakem.sv
// bagaj_hakem: controller and round-robin arbiter sharing one baggage-fee
// unit between N_KONTUAR check-in desks.
//   saat  : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : bagaj_hakem_if.master (desk requests/results, fee-unit strobe,
//           weight, synchronous reset, fee and done)
// One bag takes three cycles: BOS (arbitrate) -> HESAP (strobe fee unit,
// grant pulse) -> BEKLE (wait for done, return fee). After MAX_YOLCU bags
// the flight closes (KAPALI) until yeni_ucus reopens it and resets the fee
// unit.
// Optional macro BAGAJ_ISTATISTIK_EN adds the saturating toplam_gelir
// revenue accumulator.
module bagaj_hakem
  import bagaj_pkg::*;
#(
  parameter int N_KONTUAR = 4,
  parameter int MAX_YOLCU = MAX_YOLCU_DEF,
  parameter int AGIRLIK_W = AGIRLIK_W_DEF
) (
  input  logic          saat,
  input  logic          reset,
  bagaj_hakem_if.master bus
);

  localparam int IW = (N_KONTUAR > 1) ? $clog2(N_KONTUAR) : 1;

  durum_e               durum_q, durum_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [N_KONTUAR-1:0] kabul_q, kabul_d;
  logic [N_KONTUAR-1:0] sonuc_q, sonuc_d;
  logic [UCRET_W-1:0]   ucret_q, ucret_d;
  logic [SAYAC_W-1:0]   sayac_q, sayac_d;
  logic                 basla_q, basla_d;
  logic [AGIRLIK_W-1:0] agirlik_q, agirlik_d;
  logic                 sifirla_q, sifirla_d;
  logic [SAYAC_W-1:0]   sayac_inc;

  logic [N_KONTUAR-1:0] rr_gnt;
  logic [IW-1:0]        rr_idx;
  logic                 rr_any;

`ifdef BAGAJ_ISTATISTIK_EN
  logic [GELIR_W-1:0]   gelir_q, gelir_d;

  function automatic logic [GELIR_W-1:0] doyur_topla(
    input logic [GELIR_W-1:0] a,
    input logic [UCRET_W-1:0] b
  );
    logic [GELIR_W:0] s;
    s = {1'b0, a} + {{(GELIR_W + 1 - UCRET_W){1'b0}}, b};
    return s[GELIR_W] ? {GELIR_W{1'b1}} : s[GELIR_W-1:0];
  endfunction
`endif

  rr_hakem #(.N(N_KONTUAR), .IW(IW)) u_rr (
    .req (bus.istek),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  assign sayac_inc = sayac_q + 1'b1;

  always_comb begin
    durum_d   = durum_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    kabul_d   = '0;
    sonuc_d   = '0;
    ucret_d   = ucret_q;
    sayac_d   = sayac_q;
    basla_d   = 1'b0;
    agirlik_d = agirlik_q;
    sifirla_d = 1'b0;
`ifdef BAGAJ_ISTATISTIK_EN
    gelir_d   = gelir_q;
`endif
    unique case (durum_q)
      BOS: begin
        if (rr_any) begin
          grant_d   = rr_idx;
          ptr_d     = (rr_idx == IW'(N_KONTUAR - 1)) ? '0 : rr_idx + 1'b1;
          agirlik_d = bus.agirlik_in[int'(rr_idx)*AGIRLIK_W +: AGIRLIK_W];
          kabul_d   = rr_gnt;
          basla_d   = 1'b1;
          durum_d   = HESAP;
        end
      end
      HESAP: begin
        durum_d = BEKLE;
      end
      BEKLE: begin
        if (bus.bavul_bitti) begin
          ucret_d = bus.bavul_ucret;
          sonuc_d = N_KONTUAR'(1) << grant_q;
          sayac_d = sayac_inc;
`ifdef BAGAJ_ISTATISTIK_EN
          gelir_d = doyur_topla(gelir_q, bus.bavul_ucret);
`endif
          durum_d = (sayac_inc == SAYAC_W'(MAX_YOLCU)) ? KAPALI : BOS;
        end
      end
      KAPALI: begin
        // Requests are ignored; only a new flight leaves this state.
        if (bus.yeni_ucus) begin
          sifirla_d = 1'b1;
          sayac_d   = '0;
`ifdef BAGAJ_ISTATISTIK_EN
          gelir_d   = '0;
`endif
          durum_d   = BOS;
        end
      end
      default: durum_d = BOS;
    endcase
  end

  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      durum_q   <= BOS;
      ptr_q     <= '0;
      grant_q   <= '0;
      kabul_q   <= '0;
      sonuc_q   <= '0;
      ucret_q   <= '0;
      sayac_q   <= '0;
      basla_q   <= 1'b0;
      agirlik_q <= '0;
      // Held high through reset so the fee unit sees one clock edge with
      // its synchronous reset asserted right after release.
      sifirla_q <= 1'b1;
`ifdef BAGAJ_ISTATISTIK_EN
      gelir_q   <= '0;
`endif
    end else begin
      durum_q   <= durum_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      kabul_q   <= kabul_d;
      sonuc_q   <= sonuc_d;
      ucret_q   <= ucret_d;
      sayac_q   <= sayac_d;
      basla_q   <= basla_d;
      agirlik_q <= agirlik_d;
      sifirla_q <= sifirla_d;
`ifdef BAGAJ_ISTATISTIK_EN
      gelir_q   <= gelir_d;
`endif
    end
  end

  assign bus.kabul         = kabul_q;
  assign bus.sonuc_gecerli = sonuc_q;
  assign bus.ucret_out     = ucret_q;
  assign bus.yolcu_sayisi  = sayac_q;
  assign bus.ucus_kapali   = (durum_q == KAPALI);
  assign bus.bavul_basla   = basla_q;
  assign bus.bavul_agirlik = agirlik_q;
  assign bus.bavul_sifirla = sifirla_q;
`ifdef BAGAJ_ISTATISTIK_EN
  assign bus.toplam_gelir  = gelir_q;
`endif

endmodule

// File: tb/tb_bagaj_hakem.sv
// tb_bagaj_hakem: self-checking bench for bagaj_hakem with four desks.
// A behavioural fee unit (fee = 4*weight + 5, done one cycle after the
// strobe) is attached to the bavul_* signals. Expected grants, fees,
// counts and revenue come from a round-robin/passenger model kept here.
// Build with BAGAJ_ISTATISTIK_EN to also cover toplam_gelir.
module tb_bagaj_hakem;
  import bagaj_pkg::*;

  localparam int N    = 4;
  localparam int W    = 6;
  localparam int MAXY = 50;

  logic saat  = 1'b0;
  logic reset = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int ptr_m   = 0;
  int cnt_m   = 0;
  int gelir_m = 0;

  bagaj_hakem_if #(.N_KONTUAR(N), .AGIRLIK_W(W)) bus ();

  bagaj_hakem #(.N_KONTUAR(N), .MAX_YOLCU(MAXY), .AGIRLIK_W(W)) dut (
    .saat  (saat),
    .reset (reset),
    .bus   (bus)
  );

  always #5 saat = ~saat;

  function automatic int fee_of(input int w);
    return (4 * w + 5) % 256;
  endfunction

  // Fee unit model
  always @(posedge saat) begin
    if (bus.bavul_sifirla) begin
      bus.bavul_bitti <= 1'b0;
      bus.bavul_ucret <= 8'd0;
    end else begin
      bus.bavul_bitti <= bus.bavul_basla;
      bus.bavul_ucret <= 8'(fee_of(int'(bus.bavul_agirlik)));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Grants and results must never be multi-hot.
  always @(negedge saat) begin
    if (reset) begin
      checks++;
      assert ($onehot0(bus.kabul) && $onehot0(bus.sonuc_gecerli)) else begin
        errors++;
        $error("FAIL onehot: kabul=%b sonuc=%b expected at most one bit each",
               bus.kabul, bus.sonuc_gecerli);
      end
    end
  end

  task automatic step();
    @(posedge saat);
    #1;
  endtask

  function automatic int weight_of(input int d);
    return int'(bus.agirlik_in[d*W +: W]);
  endfunction

  // One complete bag: request sampled at the next edge, then the three
  // visible cycles are checked against the model.
  task automatic bag(input logic [N-1:0] req, input bit hold, input string tag);
    int g;
    int f;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr_m + k) % N;
      if (g < 0 && req[j]) g = j;
    end
    f = fee_of(weight_of(g));
    bus.istek = req;
    step();
    chk({tag, " kabul"},   32'(bus.kabul), 32'(1 << g));
    chk({tag, " basla"},   32'(bus.bavul_basla), 32'd1);
    chk({tag, " agirlik"}, 32'(bus.bavul_agirlik), 32'(weight_of(g)));
    chk({tag, " sonuc0"},  32'(bus.sonuc_gecerli), 32'd0);
    if (!hold) bus.istek = '0;
    ptr_m = (g + 1) % N;
    step();
    chk({tag, " kabul1"},  32'(bus.kabul), 32'd0);
    chk({tag, " basla1"},  32'(bus.bavul_basla), 32'd0);
    step();
    cnt_m++;
    gelir_m = (gelir_m + f > 65535) ? 65535 : gelir_m + f;
    chk({tag, " sonuc"},   32'(bus.sonuc_gecerli), 32'(1 << g));
    chk({tag, " ucret"},   32'(bus.ucret_out), 32'(f));
    chk({tag, " yolcu"},   32'(bus.yolcu_sayisi), 32'(cnt_m));
    chk({tag, " kapali"},  32'(bus.ucus_kapali), 32'(cnt_m == MAXY));
`ifdef BAGAJ_ISTATISTIK_EN
    chk({tag, " gelir"},   32'(bus.toplam_gelir), 32'(gelir_m));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.istek      = '0;
    bus.agirlik_in = '0;
    bus.yeni_ucus  = 1'b0;

    // Reset values
    repeat (3) step();
    chk("rst kabul",   32'(bus.kabul), 32'd0);
    chk("rst sonuc",   32'(bus.sonuc_gecerli), 32'd0);
    chk("rst ucret",   32'(bus.ucret_out), 32'd0);
    chk("rst yolcu",   32'(bus.yolcu_sayisi), 32'd0);
    chk("rst kapali",  32'(bus.ucus_kapali), 32'd0);
    chk("rst basla",   32'(bus.bavul_basla), 32'd0);
    chk("rst agirlik", 32'(bus.bavul_agirlik), 32'd0);
    chk("rst sifirla", 32'(bus.bavul_sifirla), 32'd1);
    reset = 1'b1;
    chk("rel sifirla hi", 32'(bus.bavul_sifirla), 32'd1);
    step();
    chk("rel sifirla lo", 32'(bus.bavul_sifirla), 32'd0);

    // All four desks requesting continuously: 0,1,2,3,0
    bus.agirlik_in = 24'($urandom);
    for (int b = 0; b < 5; b++) bag(4'hF, 1'b1, "rr");
    bus.istek = '0;

    // Two more bags to reach count 7
    for (int b = 0; b < 2; b++) begin
      bus.agirlik_in = 24'($urandom);
      bag(4'($urandom_range(1, 15)), 1'b0, "pre7");
    end

    // yeni_ucus outside KAPALI is ignored
    bus.yeni_ucus = 1'b1;
    step();
    bus.yeni_ucus = 1'b0;
    chk("yeni bos yolcu",   32'(bus.yolcu_sayisi), 32'd7);
    chk("yeni bos sifirla", 32'(bus.bavul_sifirla), 32'd0);
    step();
    chk("yeni bos yolcu2",  32'(bus.yolcu_sayisi), 32'd7);
    chk("yeni bos kabul",   32'(bus.kabul), 32'd0);

    // Reset while waiting for the fee unit
    bus.agirlik_in = 24'($urandom);
    bus.istek = 4'b0010;
    step();
    bus.istek = '0;
    step();
    reset = 1'b0;
    #1;
    chk("midrst kabul",   32'(bus.kabul), 32'd0);
    chk("midrst sonuc",   32'(bus.sonuc_gecerli), 32'd0);
    chk("midrst ucret",   32'(bus.ucret_out), 32'd0);
    chk("midrst yolcu",   32'(bus.yolcu_sayisi), 32'd0);
    chk("midrst basla",   32'(bus.bavul_basla), 32'd0);
    chk("midrst agirlik", 32'(bus.bavul_agirlik), 32'd0);
    chk("midrst sifirla", 32'(bus.bavul_sifirla), 32'd1);
    step();
    step();
    chk("midrst sonuc2",  32'(bus.sonuc_gecerli), 32'd0);
    reset = 1'b1;
    chk("midrel sifirla hi", 32'(bus.bavul_sifirla), 32'd1);
    step();
    chk("midrel sifirla lo", 32'(bus.bavul_sifirla), 32'd0);
    chk("midrel sonuc",      32'(bus.sonuc_gecerli), 32'd0);
    ptr_m = 0; cnt_m = 0; gelir_m = 0;

    // Pointer back at desk 0 after reset
    bus.agirlik_in = 24'($urandom);
    bag(4'b0111, 1'b0, "ptr0");

    // Random traffic until the flight closes
    while (cnt_m < MAXY) begin
      bus.agirlik_in = 24'($urandom);
      bag(4'($urandom_range(1, 15)), 1'b0, "rnd");
    end

    // Closed flight: requests ignored
    bus.istek = 4'hF;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("kapali kabul", 32'(bus.kabul), 32'd0);
      chk("kapali basla", 32'(bus.bavul_basla), 32'd0);
      chk("kapali yolcu", 32'(bus.yolcu_sayisi), 32'(MAXY));
      chk("kapali flag",  32'(bus.ucus_kapali), 32'd1);
    end
    bus.istek = '0;

    // Reopen
    bus.yeni_ucus = 1'b1;
    step();
    bus.yeni_ucus = 1'b0;
    chk("acilis sifirla", 32'(bus.bavul_sifirla), 32'd1);
    chk("acilis yolcu",   32'(bus.yolcu_sayisi), 32'd0);
    chk("acilis kapali",  32'(bus.ucus_kapali), 32'd0);
`ifdef BAGAJ_ISTATISTIK_EN
    chk("acilis gelir",   32'(bus.toplam_gelir), 32'd0);
`endif
    cnt_m = 0; gelir_m = 0;

    // Desk 2, weight 10, served on the edge right after reopening
    bus.agirlik_in = 24'($urandom);
    bus.agirlik_in[2*W +: W] = 6'd10;
    bag(4'b0100, 1'b0, "tek");
    chk("tek ucret45",  32'(bus.ucret_out), 32'd45);
    chk("tek yolcu1",   32'(bus.yolcu_sayisi), 32'd1);
    chk("tek sifirla",  32'(bus.bavul_sifirla), 32'd0);

    // Fees 45, 45, 61
    bus.agirlik_in[0*W +: W] = 6'd10;
    bag(4'b0001, 1'b0, "gelir2");
    bus.agirlik_in[1*W +: W] = 6'd14;
    bag(4'b0010, 1'b0, "gelir3");
    chk("gelir3 ucret61", 32'(bus.ucret_out), 32'd61);
`ifdef BAGAJ_ISTATISTIK_EN
    chk("gelir toplam151", 32'(bus.toplam_gelir), 32'd151);
`endif

    // ucret_out holds its value between results
    step();
    step();
    chk("ucret hold", 32'(bus.ucret_out), 32'd61);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bagaj_hakem.md
# bagaj_hakem

- Controller and round-robin arbiter that shares a single baggage-fee unit between `N_KONTUAR` check-in desks.
- Accepts one desk request at a time and drives the fee unit's `basla`/`agirlik` for one cycle. Captures the fee returned with `bitti` and routes it back to the requesting desk.
- Counts passengers and closes the flight after `MAX_YOLCU` bags. Sits between the desk front-ends and the fee unit; it issues the fee unit's synchronous reset when the design resets and when a new flight opens.

## Interface

Parameters:
- `N_KONTUAR`, 4: number of requesting desks (2..8).
- `MAX_YOLCU`, 50: bags accepted before the flight closes.
- `AGIRLIK_W`, 6: weight width per desk.

Ports:
- `saat` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `istek` input N_KONTUAR: per-desk request; held until `kabul`.
- `agirlik_in` input N_KONTUAR*AGIRLIK_W: packed weights; desk i occupies bits [i*W +: W].
- `yeni_ucus` input 1: open a new flight; honoured only in KAPALI.
- `kabul` output N_KONTUAR: one-hot, one-cycle grant pulse.
- `sonuc_gecerli` output N_KONTUAR: one-hot, one-cycle result-valid pulse.
- `ucret_out` output 8: fee for the desk flagged in `sonuc_gecerli`; holds its last value otherwise.
- `yolcu_sayisi` output 6: bags processed this flight.
- `ucus_kapali` output 1: high in KAPALI.
- `bavul_basla` output 1: start strobe to the fee unit.
- `bavul_agirlik` output AGIRLIK_W: weight to the fee unit.
- `bavul_sifirla` output 1: active-high synchronous reset to the fee unit.
- `bavul_ucret` input 8: fee from the fee unit.
- `bavul_bitti` input 1: fee-unit done.

## Operation

- FSM states: BOS (idle), HESAP (strobe), BEKLE (wait for done), KAPALI (flight closed).
- BOS:
  - If any `istek` bit is set, the round-robin arbiter picks the winner, latches its weight into `bavul_agirlik`, registers the grant index and `kabul`, then goes to HESAP.
  - With no request, stay in BOS.
- HESAP:
  - `bavul_basla`=1 for exactly this cycle.
  - `kabul`=one-hot grant for exactly this cycle.
  - Go to BEKLE.
- BEKLE:
  - `bavul_basla`=0.
  - On `bavul_bitti`=1: register `ucret_out`←`bavul_ucret`, pulse `sonuc_gecerli[grant]`, increment `yolcu_sayisi`.
  - If the new count equals `MAX_YOLCU`, go to KAPALI; otherwise go to BOS.
  - While `bavul_bitti`=0, remain in BEKLE.
- KAPALI:
  - `istek` is ignored and no `kabul` is issued.
  - On `yeni_ucus`=1: pulse `bavul_sifirla` for one cycle, clear `yolcu_sayisi`, go to BOS.
- Round-robin:
  - The search starts at index (last grant + 1) mod N.
  - The pointer advances only on grant.
  - The pointer resets to 0, so desk 0 has highest priority first.
- `yeni_ucus` outside KAPALI is ignored.
- `istek` dropped before `kabul` is not an error; arbitration uses only the BOS-cycle sample.
- Arithmetic: `yolcu_sayisi` is 6-bit and never exceeds `MAX_YOLCU`. The fee is passed through unmodified.

Reset values (asynchronous):
- State=BOS.
- `kabul`=0, `sonuc_gecerli`=0, `ucret_out`=0, `yolcu_sayisi`=0, `ucus_kapali`=0.
- `bavul_basla`=0, `bavul_agirlik`=0, round-robin pointer=0.
- `bavul_sifirla`=1; it deasserts on the first `saat` edge after `reset` releases, so the fee unit sees one synchronous reset edge.
- Reset mid-transaction abandons the request silently: no `sonuc_gecerli` is issued.

## Timing

- With the request sampled in BOS at edge t:
  - `kabul` and `bavul_basla` are high in cycle t+1.
  - The fee unit asserts `bitti` in t+2.
  - `sonuc_gecerli` and `ucret_out` are valid in t+3.
- Throughput: one bag per 3 cycles (BOS→HESAP→BEKLE→BOS).
- All outputs are registered; no combinational path from `istek` to any output.
- Closing bag (count reaching `MAX_YOLCU`): `ucus_kapali` rises in the same cycle as its `sonuc_gecerli`.
- `yeni_ucus` at edge k: `bavul_sifirla`=1 and `yolcu_sayisi`=0 in cycle k+1; BOS accepts requests at edge k+1.

## Configuration

- `BAGAJ_ISTATISTIK_EN` defined:
  - Adds output `toplam_gelir` [15:0], the sum of delivered fees for this flight.
  - It saturates at 16'hFFFF.
  - It clears on reset and on `yeni_ucus`, and updates in the same cycle as `sonuc_gecerli`.
- Undefined: the port and its accumulator are absent; all other behaviour is identical.

## Structure

- Package `bagaj_pkg`:
  - State enum (BOS, HESAP, BEKLE, KAPALI).
  - Default constants for `MAX_YOLCU`, `AGIRLIK_W` and fee width (8).
  - Counter width (6).
- Sub-module `rr_hakem`, parameterised by N:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, grant index, any-valid.
  - Purely combinational; the pointer register lives in `bagaj_hakem`.
- The fee unit is not instantiated inside; the top level connects it to the `bavul_*` ports.

## Test plan

- Single request:
  - Stimulus: desk 2, weight 10.
  - Required: `kabul`=4'b0100 at t+1, `bavul_basla` one cycle with `bavul_agirlik`=10; `sonuc_gecerli`=4'b0100 at t+3, `ucret_out`=45, `yolcu_sayisi`=1.
- All four desks request continuously:
  - Required: grants in order 0,1,2,3,0, each 3 cycles apart; `kabul` is never multi-hot.
- Close and reopen:
  - Stimulus: 50 bags.
  - Required: `ucus_kapali`=1 with the 50th `sonuc_gecerli`, and further `istek` gets no `kabul`. `yeni_ucus` → one-cycle `bavul_sifirla`, `yolcu_sayisi`=0, the next request is served.
- Reset asserted in BEKLE:
  - Required: every output returns to its reset value immediately with no `sonuc_gecerli`. After release, `bavul_sifirla`=1 for one cycle and the pointer restarts at desk 0.
- `yeni_ucus` pulsed in BOS with count 7:
  - Required: ignored; count stays 7 and `bavul_sifirla` stays 0.
- `BAGAJ_ISTATISTIK_EN` build:
  - Stimulus: fees 45, 45, 61.
  - Required: `toplam_gelir`=151; it clears to 0 after `yeni_ucus`.
